axi_join_pipe: RTL and testbench
================================

AXI_JOIN_PIPE -- requirements
Module: axi_join_pipe

Interface
REQ-001 SHALL have parameter SlvIdWidth, default 4: ID width of the slave-side (upstream) port.
REQ-002 SHALL have parameter MstIdWidth, default 4: ID width of the master-side (downstream) port.
REQ-003 SHALL have parameters AwDepth, WDepth, BDepth, ArDepth, RDepth, each default 1, legal values 0/1/2: pipeline mode per channel.
REQ-004 SHALL have type parameters slv_req_t, slv_resp_t, mst_req_t, mst_resp_t (axi_pkg-style request/response structs), defaults from the shared package.
REQ-005 Ports:
clk_i       input   1           clock; all logic on the rising edge
rst_ni      input   1           reset; synchronous, active-low
slv_req_i   input   slv_req_t   upstream AW/W/AR payload+valid, B/R ready
slv_resp_o  output  slv_resp_t  upstream AW/W/AR ready, B/R payload+valid
mst_req_o   output  mst_req_t   downstream request
mst_resp_i  input   mst_resp_t  downstream response
busy_o      output  1           any pipeline stage holds a beat

Function
REQ-006 Each of the five channels SHALL pass through one independent stage configured by its Depth parameter.
REQ-007 Depth 0 SHALL be a combinational wire: valid, ready and payload pass in zero cycles.
REQ-008 Depth 1 SHALL be a pass register: payload/valid registered, 1-cycle latency, ready_up = ~full | ready_dn (combinational ready path), throughput 1 beat/cycle.
REQ-009 Depth 2 SHALL be a spill register: 2 entries, ready_up = ~(both entries full), registered, no combinational path in either direction, 1-cycle latency when empty, throughput 1 beat/cycle.
REQ-010 A beat SHALL transfer on a port only when valid & ready are both high in the same cycle.
REQ-011 Once an output valid is high, it and its payload SHALL hold unchanged until the matching ready is sampled high.
REQ-012 A stage SHALL NOT drop, duplicate or reorder beats; order within a channel is preserved.
REQ-013 Simultaneous enqueue and dequeue on a full Depth-1 stage, or a one-entry Depth-2 stage, SHALL complete both in the same cycle with occupancy unchanged.
REQ-014 AW and AR IDs SHALL be zero-extended from SlvIdWidth to MstIdWidth on entry.
REQ-015 B and R IDs SHALL be truncated to the low SlvIdWidth bits on exit.
REQ-016 All other fields (addr, data, strb, last, user, len, size, burst, cache, prot, qos, region, atop, resp) SHALL pass bit-exact.
REQ-017 busy_o SHALL be the OR of all stage occupancy flags, registered-state derived only (no input dependency).
REQ-018 MstIdWidth < SlvIdWidth, or any Depth outside 0..2, SHALL cause an elaboration-time error.

Reset
REQ-019 While rst_ni is low at a rising edge, every stage SHALL become empty on that edge.
REQ-020 After reset: all output valids = 0; busy_o = 0; Depth-1/2 ready_up outputs = 1; Depth-0 channels follow their inputs.
REQ-021 Reset asserted mid-burst SHALL discard held beats; no partial beat SHALL appear after release.

Structure
REQ-022 Depth encoding constants (CUT_NONE=0, CUT_PIPE=1, CUT_SPILL=2) and the default channel/req/resp typedefs SHALL live in the shared axi package.
REQ-023 One generic sub-module axi_chan_slice (parameters: payload type, Depth) SHALL implement the stage and be instantiated five times, with the ID width change done outside it.

Verification
REQ-024 All Depth=1, SlvIdWidth=4, MstIdWidth=6: AW id 4'hA, addr 0x1000 valid at cycle 0 with mst ready high -> mst AW valid at cycle 1, id 6'h0A, addr 0x1000; B id 6'h0A returned -> slv B id 4'hA one cycle later.
REQ-025 WDepth=2, 8-beat burst data 0..7, mst W ready held low for 4 cycles -> slv W ready drops after 2 beats accepted; after release, mst sees 0..7 in order, no gaps once ready stays high, payload stable while stalled.
REQ-026 RDepth=1, continuous R valid and ready for 16 beats -> 16 beats out in 16 consecutive cycles after the 1-cycle latency.
REQ-027 All Depth=0 -> every output equals its input in the same cycle; busy_o constant 0.
REQ-028 ArDepth=2 full with 2 beats, rst_ni low for one edge -> next cycle mst AR valid = 0, busy_o = 0, slv AR ready = 1; the two beats never appear downstream.
REQ-029 Random valid/ready toggling on all five channels, 10k cycles, Depth mix {0,1,2,1,2} -> scoreboard: no loss, duplication or reordering per channel; zero AXI stability violations.

Source files
------------

// File: rtl/axi_join_pipe_pkg.sv
// Shared AXI types and cut-mode constants for axi_join_pipe.
// The id field is the MSB of every id-carrying channel struct.
package axi_join_pipe_pkg;

  localparam int unsigned CUT_NONE  = 0;
  localparam int unsigned CUT_PIPE  = 1;
  localparam int unsigned CUT_SPILL = 2;

  localparam int unsigned IdWidth     = 4;
  localparam int unsigned WideIdWidth = 6;
  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned DataWidth   = 32;
  localparam int unsigned UserWidth   = 1;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ax_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_body_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_body_t;

  // Id first, so widening is a zero-extend and narrowing a truncate
  typedef struct packed {
    logic [IdWidth-1:0] id;
    ax_t                ax;
    logic [5:0]         atop;
  } aw_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    ax_t                ax;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    b_body_t            body;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    r_body_t            body;
  } r_chan_t;

  typedef struct packed {
    logic [WideIdWidth-1:0] id;
    ax_t                    ax;
    logic [5:0]             atop;
  } aw_chan_w_t;

  typedef struct packed {
    logic [WideIdWidth-1:0] id;
    ax_t                    ax;
  } ar_chan_w_t;

  typedef struct packed {
    logic [WideIdWidth-1:0] id;
    b_body_t                body;
  } b_chan_w_t;

  typedef struct packed {
    logic [WideIdWidth-1:0] id;
    r_body_t                body;
  } r_chan_w_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  typedef struct packed {
    aw_chan_w_t aw;
    logic       aw_valid;
    w_chan_t    w;
    logic       w_valid;
    logic       b_ready;
    ar_chan_w_t ar;
    logic       ar_valid;
    logic       r_ready;
  } req_w_t;

  typedef struct packed {
    logic      aw_ready;
    logic      ar_ready;
    logic      w_ready;
    logic      b_valid;
    b_chan_w_t b;
    logic      r_valid;
    r_chan_w_t r;
  } resp_w_t;

endpackage

// File: rtl/axi_join_pipe_if.sv
// AXI request/response bundle for one side of axi_join_pipe.
// master drives req, slave drives resp.
interface axi_join_pipe_if #(
  parameter type req_t  = axi_join_pipe_pkg::req_t,
  parameter type resp_t = axi_join_pipe_pkg::resp_t
);
  req_t  req;
  resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/axi_join_pipe_chan.sv
// Generic one-channel valid/ready stage: wire, pass
// register or two-entry spill register.
module axi_chan_slice
  import axi_join_pipe_pkg::*;
#(
  parameter type         T     = logic,
  parameter int unsigned Depth = CUT_PIPE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o,
  output logic busy_o
);

  if (Depth == CUT_NONE) begin : g_none
    logic w_unused;
    assign w_unused = clk_i ^ rst_ni;
    assign valid_o  = valid_i;
    assign ready_o  = ready_i;
    assign data_o   = data_i;
    assign busy_o   = 1'b0;
  end else if (Depth == CUT_PIPE) begin : g_pipe
    logic r_full;
    T     r_data;

    assign ready_o = ~r_full | ready_i;

    // Reload whenever the slot is empty or drains this cycle
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_full <= 1'b0;
        r_data <= '0;
      end else if (ready_o) begin
        r_full <= valid_i;
        if (valid_i) r_data <= data_i;
      end
    end

    assign valid_o = r_full;
    assign data_o  = r_data;
    assign busy_o  = r_full;
  end else if (Depth == CUT_SPILL) begin : g_spill
    logic r_a_full;
    logic r_b_full;
    T     r_a_data;
    T     r_b_data;
    logic w_enq;
    logic w_deq;

    assign ready_o = ~r_b_full;
    assign w_enq   = valid_i & ~r_b_full;
    assign w_deq   = r_a_full & ready_i;

    // A is the output slot, B only catches a beat while A stalls
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_a_full <= 1'b0;
        r_b_full <= 1'b0;
        r_a_data <= '0;
        r_b_data <= '0;
      end else if (w_deq && r_b_full) begin
        r_a_data <= r_b_data;
        r_b_full <= 1'b0;
      end else if (w_enq && (!r_a_full || w_deq)) begin
        r_a_data <= data_i;
        r_a_full <= 1'b1;
      end else if (w_enq) begin
        r_b_data <= data_i;
        r_b_full <= 1'b1;
      end else if (w_deq) begin
        r_a_full <= 1'b0;
      end
    end

    assign valid_o = r_a_full;
    assign data_o  = r_a_data;
    assign busy_o  = r_a_full | r_b_full;
  end else begin : g_bad
    $error("axi_chan_slice: Depth must be 0, 1 or 2");
  end

endmodule

// File: rtl/axi_join_pipe.sv
// AXI join with a configurable cut on each of the five
// channels and an ID width change between the ports.
module axi_join_pipe
  import axi_join_pipe_pkg::*;
#(
  parameter int unsigned SlvIdWidth = 4,
  parameter int unsigned MstIdWidth = 4,
  parameter int unsigned AwDepth    = CUT_PIPE,
  parameter int unsigned WDepth     = CUT_PIPE,
  parameter int unsigned BDepth     = CUT_PIPE,
  parameter int unsigned ArDepth    = CUT_PIPE,
  parameter int unsigned RDepth     = CUT_PIPE,
  parameter type slv_req_t  = req_t,
  parameter type slv_resp_t = resp_t,
  parameter type mst_req_t  = req_t,
  parameter type mst_resp_t = resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  slv_req_t  slv_req_i,
  output slv_resp_t slv_resp_o,
  output mst_req_t  mst_req_o,
  input  mst_resp_t mst_resp_i,
  output logic      busy_o
);

  localparam int AwSW = $bits(slv_req_i.aw);
  localparam int AwMW = $bits(mst_req_o.aw);
  localparam int ArSW = $bits(slv_req_i.ar);
  localparam int ArMW = $bits(mst_req_o.ar);
  localparam int BSW  = $bits(slv_resp_o.b);
  localparam int BMW  = $bits(mst_resp_i.b);
  localparam int RSW  = $bits(slv_resp_o.r);
  localparam int RMW  = $bits(mst_resp_i.r);
  localparam int WW   = $bits(slv_req_i.w);
  localparam int IdD  = int'(MstIdWidth) - int'(SlvIdWidth);

  if (MstIdWidth < SlvIdWidth) begin : g_err_id
    $error("axi_join_pipe: MstIdWidth < SlvIdWidth");
  end
  if (AwMW - AwSW != IdD || ArMW - ArSW != IdD ||
      BMW - BSW != IdD || RMW - RSW != IdD) begin : g_err_ty
    $error("axi_join_pipe: struct ids disagree with widths");
  end

  typedef logic [AwMW-1:0] aw_vec_t;
  typedef logic [ArMW-1:0] ar_vec_t;
  typedef logic [BMW-1:0]  b_vec_t;
  typedef logic [RMW-1:0]  r_vec_t;
  typedef logic [WW-1:0]   w_vec_t;

  aw_vec_t    w_aw_in;
  aw_vec_t    w_aw_out;
  ar_vec_t    w_ar_in;
  ar_vec_t    w_ar_out;
  b_vec_t     w_b_out;
  r_vec_t     w_r_out;
  w_vec_t     w_w_out;
  logic       w_aw_valid, w_aw_ready;
  logic       w_w_valid,  w_w_ready;
  logic       w_b_valid,  w_b_ready;
  logic       w_ar_valid, w_ar_ready;
  logic       w_r_valid,  w_r_ready;
  logic [4:0] w_busy;
  logic       w_unused;

  assign w_aw_in  = aw_vec_t'(slv_req_i.aw);
  assign w_ar_in  = ar_vec_t'(slv_req_i.ar);
  assign w_unused = |{w_b_out >> BSW, w_r_out >> RSW};

  axi_chan_slice #(.T(aw_vec_t), .Depth(AwDepth)) i_aw (
    .clk_i, .rst_ni,
    .valid_i (slv_req_i.aw_valid),
    .ready_o (w_aw_ready),
    .data_i  (w_aw_in),
    .valid_o (w_aw_valid),
    .ready_i (mst_resp_i.aw_ready),
    .data_o  (w_aw_out),
    .busy_o  (w_busy[0])
  );

  axi_chan_slice #(.T(w_vec_t), .Depth(WDepth)) i_w (
    .clk_i, .rst_ni,
    .valid_i (slv_req_i.w_valid),
    .ready_o (w_w_ready),
    .data_i  (slv_req_i.w),
    .valid_o (w_w_valid),
    .ready_i (mst_resp_i.w_ready),
    .data_o  (w_w_out),
    .busy_o  (w_busy[1])
  );

  axi_chan_slice #(.T(b_vec_t), .Depth(BDepth)) i_b (
    .clk_i, .rst_ni,
    .valid_i (mst_resp_i.b_valid),
    .ready_o (w_b_ready),
    .data_i  (mst_resp_i.b),
    .valid_o (w_b_valid),
    .ready_i (slv_req_i.b_ready),
    .data_o  (w_b_out),
    .busy_o  (w_busy[2])
  );

  axi_chan_slice #(.T(ar_vec_t), .Depth(ArDepth)) i_ar (
    .clk_i, .rst_ni,
    .valid_i (slv_req_i.ar_valid),
    .ready_o (w_ar_ready),
    .data_i  (w_ar_in),
    .valid_o (w_ar_valid),
    .ready_i (mst_resp_i.ar_ready),
    .data_o  (w_ar_out),
    .busy_o  (w_busy[3])
  );

  axi_chan_slice #(.T(r_vec_t), .Depth(RDepth)) i_r (
    .clk_i, .rst_ni,
    .valid_i (mst_resp_i.r_valid),
    .ready_o (w_r_ready),
    .data_i  (mst_resp_i.r),
    .valid_o (w_r_valid),
    .ready_i (slv_req_i.r_ready),
    .data_o  (w_r_out),
    .busy_o  (w_busy[4])
  );

  // Repack stage outputs; B/R ids lose their upper bits here
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = w_aw_out;
    mst_req_o.aw_valid = w_aw_valid;
    mst_req_o.w        = w_w_out;
    mst_req_o.w_valid  = w_w_valid;
    mst_req_o.b_ready  = w_b_ready;
    mst_req_o.ar       = w_ar_out;
    mst_req_o.ar_valid = w_ar_valid;
    mst_req_o.r_ready  = w_r_ready;
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = w_aw_ready;
    slv_resp_o.w_ready  = w_w_ready;
    slv_resp_o.ar_ready = w_ar_ready;
    slv_resp_o.b_valid  = w_b_valid;
    slv_resp_o.b        = w_b_out[BSW-1:0];
    slv_resp_o.r_valid  = w_r_valid;
    slv_resp_o.r        = w_r_out[RSW-1:0];
  end

  assign busy_o = |w_busy;

endmodule

// File: tb/tb_axi_join_pipe.sv
// Directed and randomised checks of axi_join_pipe.
// dut_a: mixed cuts, 4->6 ids; dut_z: all wires.
module tb_axi_join_pipe;
  import axi_join_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  logic busy_a;
  logic busy_z;

  always #5 clk = ~clk;

  axi_join_pipe_if #(.req_t(req_t), .resp_t(resp_t)) slv_a ();
  axi_join_pipe_if #(.req_t(req_w_t), .resp_t(resp_w_t)) mst_a ();
  axi_join_pipe_if #(.req_t(req_t), .resp_t(resp_t)) slv_z ();
  axi_join_pipe_if #(.req_t(req_t), .resp_t(resp_t)) mst_z ();

  axi_join_pipe #(
    .SlvIdWidth(4), .MstIdWidth(6),
    .AwDepth(1), .WDepth(2), .BDepth(1),
    .ArDepth(2), .RDepth(1),
    .slv_req_t(req_t), .slv_resp_t(resp_t),
    .mst_req_t(req_w_t), .mst_resp_t(resp_w_t)
  ) dut_a (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (slv_a.req),
    .slv_resp_o (slv_a.resp),
    .mst_req_o  (mst_a.req),
    .mst_resp_i (mst_a.resp),
    .busy_o     (busy_a)
  );

  axi_join_pipe #(
    .SlvIdWidth(4), .MstIdWidth(4),
    .AwDepth(0), .WDepth(0), .BDepth(0),
    .ArDepth(0), .RDepth(0),
    .slv_req_t(req_t), .slv_resp_t(resp_t),
    .mst_req_t(req_t), .mst_resp_t(resp_t)
  ) dut_z (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (slv_z.req),
    .slv_resp_o (slv_z.resp),
    .mst_req_o  (mst_z.req),
    .mst_resp_i (mst_z.resp),
    .busy_o     (busy_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    slv_a.req  = '0;
    mst_a.resp = '0;
    slv_z.req  = '0;
    mst_z.resp = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mid();
    checks++;
    if ({mst_a.req.aw_valid, mst_a.req.w_valid,
         mst_a.req.ar_valid, slv_a.resp.b_valid,
         slv_a.resp.r_valid} !== 5'b0) begin
      errs++;
      $display("FAIL rst_valids: got %b exp 00000",
        {mst_a.req.aw_valid, mst_a.req.w_valid,
         mst_a.req.ar_valid, slv_a.resp.b_valid,
         slv_a.resp.r_valid});
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errs++;
      $display("FAIL rst_busy: got %b exp 0", busy_a);
    end
    checks++;
    if ({slv_a.resp.aw_ready, slv_a.resp.w_ready,
         slv_a.resp.ar_ready, mst_a.req.b_ready,
         mst_a.req.r_ready} !== 5'b11111) begin
      errs++;
      $display("FAIL rst_readies: got %b exp 11111",
        {slv_a.resp.aw_ready, slv_a.resp.w_ready,
         slv_a.resp.ar_ready, mst_a.req.b_ready,
         mst_a.req.r_ready});
    end
    checks++;
    if (slv_z.resp.aw_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_z_ready: got %b exp 0",
        slv_z.resp.aw_ready);
    end
  endtask

  task automatic test_depth0();
    req_t  rq;
    resp_t rs;
    for (int p = 0; p < 2; p++) begin
      tick();
      rq = '0;
      rs = '0;
      rq.aw.id      = (p == 0) ? 4'hC : 4'h3;
      rq.aw.ax.addr = (p == 0) ? 32'h1234_5678 : 32'hDEAD_BEEF;
      rq.aw.atop    = (p == 0) ? 6'h2A : 6'h15;
      rq.aw_valid   = (p == 1);
      rq.w.data     = (p == 0) ? 32'hCAFE_0001 : 32'h0BAD_F00D;
      rq.w.strb     = (p == 0) ? 4'h5 : 4'hA;
      rq.w_valid    = (p == 0);
      rq.ar.id      = 4'h7;
      rq.ar.ax.len  = (p == 0) ? 8'd15 : 8'd0;
      rq.ar_valid   = (p == 0);
      rq.b_ready    = (p == 1);
      rq.r_ready    = (p == 0);
      rs.aw_ready   = (p == 0);
      rs.w_ready    = (p == 1);
      rs.ar_ready   = (p == 1);
      rs.b_valid    = 1'b1;
      rs.b.id       = (p == 0) ? 4'h9 : 4'h6;
      rs.b.body.resp = 2'(p + 1);
      rs.r_valid    = (p == 1);
      rs.r.body.data = (p == 0) ? 32'h5555_AAAA : 32'h0F0F_F0F0;
      rs.r.body.last = (p == 1);
      slv_z.req  = rq;
      mst_z.resp = rs;
      mid();
      checks++;
      if (mst_z.req !== rq) begin
        errs++;
        $display("FAIL z_req%0d: got %h exp %h",
          p, mst_z.req, rq);
      end
      checks++;
      if (slv_z.resp !== rs) begin
        errs++;
        $display("FAIL z_resp%0d: got %h exp %h",
          p, slv_z.resp, rs);
      end
      checks++;
      if (busy_z !== 1'b0) begin
        errs++;
        $display("FAIL z_busy%0d: got %b exp 0", p, busy_z);
      end
    end
    idle();
  endtask

  task automatic test_aw_b();
    tick();
    slv_a.req.aw.id      = 4'hA;
    slv_a.req.aw.ax.addr = 32'h1000;
    slv_a.req.aw.ax.len  = 8'd3;
    slv_a.req.aw.atop    = 6'h15;
    slv_a.req.aw_valid   = 1'b1;
    mst_a.resp.aw_ready  = 1'b1;
    mid();
    checks++;
    if (mst_a.req.aw_valid !== 1'b0) begin
      errs++;
      $display("FAIL aw_lat0: got %b exp 0",
        mst_a.req.aw_valid);
    end
    tick();
    slv_a.req.aw_valid = 1'b0;
    mid();
    checks++;
    if (mst_a.req.aw_valid !== 1'b1 ||
        mst_a.req.aw.id !== 6'h0A ||
        mst_a.req.aw.ax.addr !== 32'h1000) begin
      errs++;
      $display("FAIL aw_out: got v=%b id=%h a=%h exp 1 0a 1000",
        mst_a.req.aw_valid, mst_a.req.aw.id,
        mst_a.req.aw.ax.addr);
    end
    checks++;
    if (mst_a.req.aw.ax.len !== 8'd3 ||
        mst_a.req.aw.atop !== 6'h15) begin
      errs++;
      $display("FAIL aw_fields: got len=%h atop=%h exp 3 15",
        mst_a.req.aw.ax.len, mst_a.req.aw.atop);
    end
    tick();
    mid();
    checks++;
    if (mst_a.req.aw_valid !== 1'b0) begin
      errs++;
      $display("FAIL aw_drain: got %b exp 0",
        mst_a.req.aw_valid);
    end
    tick();
    mst_a.resp.b_valid     = 1'b1;
    mst_a.resp.b.id        = 6'h0A;
    mst_a.resp.b.body.resp = 2'b10;
    slv_a.req.b_ready      = 1'b1;
    mid();
    checks++;
    if (slv_a.resp.b_valid !== 1'b0) begin
      errs++;
      $display("FAIL b_lat0: got %b exp 0",
        slv_a.resp.b_valid);
    end
    tick();
    mst_a.resp.b.id        = 6'h35;
    mst_a.resp.b.body.resp = 2'b01;
    mid();
    checks++;
    if (slv_a.resp.b_valid !== 1'b1 ||
        slv_a.resp.b.id !== 4'hA ||
        slv_a.resp.b.body.resp !== 2'b10) begin
      errs++;
      $display("FAIL b_out0: got v=%b id=%h r=%b exp 1 a 10",
        slv_a.resp.b_valid, slv_a.resp.b.id,
        slv_a.resp.b.body.resp);
    end
    checks++;
    if (mst_a.req.b_ready !== 1'b1) begin
      errs++;
      $display("FAIL b_full_ready: got %b exp 1",
        mst_a.req.b_ready);
    end
    tick();
    mst_a.resp.b_valid = 1'b0;
    mid();
    checks++;
    if (slv_a.resp.b_valid !== 1'b1 ||
        slv_a.resp.b.id !== 4'h5 ||
        slv_a.resp.b.body.resp !== 2'b01) begin
      errs++;
      $display("FAIL b_out1: got v=%b id=%h r=%b exp 1 5 01",
        slv_a.resp.b_valid, slv_a.resp.b.id,
        slv_a.resp.b.body.resp);
    end
    tick();
    mid();
    checks++;
    if (slv_a.resp.b_valid !== 1'b0) begin
      errs++;
      $display("FAIL b_drain: got %b exp 0",
        slv_a.resp.b_valid);
    end
    idle();
  endtask

  task automatic test_w_spill();
    int      sent = 0;
    int      got = 0;
    int      first = -1;
    int      lastc = -1;
    logic    hold = 1'b0;
    w_chan_t held = '0;
    for (int c = 0; c < 30; c++) begin
      tick();
      mst_a.resp.w_ready = (c >= 4);
      slv_a.req.w_valid  = (sent < 8);
      slv_a.req.w.data   = 32'(sent);
      slv_a.req.w.strb   = 4'hF;
      slv_a.req.w.last   = (sent == 7);
      mid();
      if (c == 2 || c == 3) begin
        checks++;
        if (slv_a.resp.w_ready !== 1'b0) begin
          errs++;
          $display("FAIL w_stall_ready c%0d: got %b exp 0",
            c, slv_a.resp.w_ready);
        end
      end
      if (hold) begin
        checks++;
        if (mst_a.req.w_valid !== 1'b1 ||
            mst_a.req.w !== held) begin
          errs++;
          $display("FAIL w_stable c%0d: got %b/%h exp 1/%h",
            c, mst_a.req.w_valid, mst_a.req.w, held);
        end
      end
      if (mst_a.req.w_valid && mst_a.resp.w_ready) begin
        checks++;
        if (mst_a.req.w.data !== 32'(got) ||
            mst_a.req.w.last !== (got == 7)) begin
          errs++;
          $display("FAIL w_beat%0d: got %h/%b exp %h/%b",
            got, mst_a.req.w.data, mst_a.req.w.last,
            got, (got == 7));
        end
        if (first < 0) first = c;
        lastc = c;
        got++;
      end
      hold = mst_a.req.w_valid & ~mst_a.resp.w_ready;
      held = mst_a.req.w;
      if (slv_a.req.w_valid && slv_a.resp.w_ready) sent++;
      if (c == 3) begin
        checks++;
        if (sent !== 2) begin
          errs++;
          $display("FAIL w_accepted: got %0d exp 2", sent);
        end
      end
    end
    checks++;
    if (got !== 8 || first !== 4 || lastc !== 11) begin
      errs++;
      $display("FAIL w_burst: got n=%0d %0d..%0d exp 8 4..11",
        got, first, lastc);
    end
    idle();
  endtask

  task automatic test_r_stream();
    int rdy_drops = 0;
    slv_a.req.r_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      tick();
      mst_a.resp.r_valid        = (c < 16);
      mst_a.resp.r.id           = 6'h3C;
      mst_a.resp.r.body.data    = 32'hA000 + 32'(c);
      mst_a.resp.r.body.last    = (c == 15);
      mid();
      if (c < 16 && mst_a.req.r_ready !== 1'b1) rdy_drops++;
      if (c >= 1 && c <= 16) begin
        checks++;
        if (slv_a.resp.r_valid !== 1'b1 ||
            slv_a.resp.r.id !== 4'hC ||
            slv_a.resp.r.body.data !== 32'hA000 + 32'(c - 1) ||
            slv_a.resp.r.body.last !== (c == 16)) begin
          errs++;
          $display("FAIL r_beat c%0d: got %b/%h/%h exp 1/c/%h",
            c, slv_a.resp.r_valid, slv_a.resp.r.id,
            slv_a.resp.r.body.data, 32'hA000 + 32'(c - 1));
        end
      end
      if (c == 17) begin
        checks++;
        if (slv_a.resp.r_valid !== 1'b0) begin
          errs++;
          $display("FAIL r_drain: got %b exp 0",
            slv_a.resp.r_valid);
        end
      end
    end
    checks++;
    if (rdy_drops !== 0) begin
      errs++;
      $display("FAIL r_ready_drops: got %0d exp 0", rdy_drops);
    end
    idle();
  endtask

  task automatic test_ar_reset();
    int leaks = 0;
    tick();
    slv_a.req.ar_valid   = 1'b1;
    slv_a.req.ar.ax.addr = 32'hA0;
    tick();
    slv_a.req.ar.ax.addr = 32'hA4;
    tick();
    slv_a.req.ar_valid   = 1'b0;
    mid();
    checks++;
    if (slv_a.resp.ar_ready !== 1'b0 || busy_a !== 1'b1) begin
      errs++;
      $display("FAIL ar_full: got rdy=%b busy=%b exp 0 1",
        slv_a.resp.ar_ready, busy_a);
    end
    checks++;
    if (mst_a.req.ar_valid !== 1'b1 ||
        mst_a.req.ar.ax.addr !== 32'hA0) begin
      errs++;
      $display("FAIL ar_head: got %b/%h exp 1/a0",
        mst_a.req.ar_valid, mst_a.req.ar.ax.addr);
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mid();
    checks++;
    if (mst_a.req.ar_valid !== 1'b0 || busy_a !== 1'b0 ||
        slv_a.resp.ar_ready !== 1'b1) begin
      errs++;
      $display("FAIL ar_rst: got v=%b busy=%b rdy=%b exp 0 0 1",
        mst_a.req.ar_valid, busy_a, slv_a.resp.ar_ready);
    end
    mst_a.resp.ar_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      mid();
      if (mst_a.req.ar_valid !== 1'b0) leaks++;
    end
    checks++;
    if (leaks !== 0) begin
      errs++;
      $display("FAIL ar_leak: got %0d exp 0", leaks);
    end
    idle();
  endtask

  task automatic test_random();
    int      w_seq = 0;
    int      r_seq = 0;
    int      w_got = 0;
    int      r_got = 0;
    int      ex;
    int      wq[$];
    int      rq[$];
    logic    w_v = 1'b0;
    logic    r_v = 1'b0;
    logic    w_fire = 1'b0;
    logic    r_fire = 1'b0;
    logic    w_hold = 1'b0;
    logic    r_hold = 1'b0;
    w_chan_t w_held = '0;
    r_chan_t r_held = '0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (w_fire) begin w_seq++; w_v = 1'b0; end
      if (r_fire) begin r_seq++; r_v = 1'b0; end
      if (!w_v && w_seq < 200) w_v = 1'($urandom_range(0, 1));
      if (!r_v && r_seq < 200) r_v = 1'($urandom_range(0, 1));
      slv_a.req.w_valid = w_v;
      slv_a.req.w.data  = 32'(w_seq);
      slv_a.req.w.last  = (w_seq % 3 == 0);
      mst_a.resp.r_valid     = r_v;
      mst_a.resp.r.body.data = 32'h100 + 32'(r_seq);
      mst_a.resp.w_ready = (c >= 1600) ? 1'b1
                           : 1'($urandom_range(0, 1));
      slv_a.req.r_ready  = (c >= 1600) ? 1'b1
                           : 1'($urandom_range(0, 1));
      mid();
      w_fire = w_v & slv_a.resp.w_ready;
      r_fire = r_v & mst_a.req.r_ready;
      if (w_fire) wq.push_back(w_seq);
      if (r_fire) rq.push_back(r_seq);
      if (w_hold) begin
        checks++;
        if (mst_a.req.w_valid !== 1'b1 ||
            mst_a.req.w !== w_held) begin
          errs++;
          $display("FAIL rnd_w_stable c%0d: got %b/%h exp 1/%h",
            c, mst_a.req.w_valid, mst_a.req.w, w_held);
        end
      end
      if (r_hold) begin
        checks++;
        if (slv_a.resp.r_valid !== 1'b1 ||
            slv_a.resp.r !== r_held) begin
          errs++;
          $display("FAIL rnd_r_stable c%0d: got %b/%h exp 1/%h",
            c, slv_a.resp.r_valid, slv_a.resp.r, r_held);
        end
      end
      if (mst_a.req.w_valid && mst_a.resp.w_ready) begin
        ex = (wq.size() == 0) ? -1 : wq.pop_front();
        checks++;
        if (mst_a.req.w.data !== 32'(ex) ||
            mst_a.req.w.last !== (ex % 3 == 0)) begin
          errs++;
          $display("FAIL rnd_w c%0d: got %h exp %h",
            c, mst_a.req.w.data, 32'(ex));
        end
        w_got++;
      end
      if (slv_a.resp.r_valid && slv_a.req.r_ready) begin
        ex = (rq.size() == 0) ? -1 : rq.pop_front();
        checks++;
        if (slv_a.resp.r.body.data !== 32'h100 + 32'(ex)) begin
          errs++;
          $display("FAIL rnd_r c%0d: got %h exp %h",
            c, slv_a.resp.r.body.data, 32'h100 + 32'(ex));
        end
        r_got++;
      end
      w_hold = mst_a.req.w_valid & ~mst_a.resp.w_ready;
      w_held = mst_a.req.w;
      r_hold = slv_a.resp.r_valid & ~slv_a.req.r_ready;
      r_held = slv_a.resp.r;
    end
    checks++;
    if (w_got !== 200 || r_got !== 200 ||
        wq.size() != 0 || rq.size() != 0) begin
      errs++;
      $display("FAIL rnd_count: got w=%0d r=%0d exp 200 200",
        w_got, r_got);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errs++;
      $display("FAIL rnd_idle_busy: got %b exp 0", busy_a);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_depth0();
    test_aw_b();
    test_w_spill();
    test_r_stream();
    test_ar_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
